// File: rtl/srl_ll_seq_if.sv
// ---------------------------------------------------------------------------
// srl_ll_seq_if -- operand/result bundle for the iterative 64-bit right shifter.
//
// Signals:
//   start             request to begin a shift (one cycle, honoured only when idle)
//   in_high, in_low   upper/lower words of the 64-bit operand
//   amount            unsigned shift count
//   arith             arithmetic-shift select (only with SRL_LL_SEQ_ARITH_EN)
//   res_high, res_low upper/lower words of the 64-bit result
//   busy              high while shifting
//   done              one-cycle completion pulse
//
// Modports:
//   master  -- the requester (drives operands, observes results)
//   slave   -- the shifter
//
// Build option: define SRL_LL_SEQ_ARITH_EN to add the arith signal.
// ---------------------------------------------------------------------------
interface srl_ll_seq_if;
    logic        start;
    logic [31:0] in_high;
    logic [31:0] in_low;
    logic [31:0] amount;
`ifdef SRL_LL_SEQ_ARITH_EN
    logic        arith;
`endif
    logic [31:0] res_high;
    logic [31:0] res_low;
    logic        busy;
    logic        done;

`ifdef SRL_LL_SEQ_ARITH_EN
    modport master (
        output start, in_high, in_low, amount, arith,
        input  res_high, res_low, busy, done
    );
    modport slave (
        input  start, in_high, in_low, amount, arith,
        output res_high, res_low, busy, done
    );
`else
    modport master (
        output start, in_high, in_low, amount,
        input  res_high, res_low, busy, done
    );
    modport slave (
        input  start, in_high, in_low, amount,
        output res_high, res_low, busy, done
    );
`endif
endinterface

// File: rtl/srl_ll_seq.sv
// ---------------------------------------------------------------------------
// srl_ll_seq -- iterative 64-bit right shifter.
//
// Shifts {in_high,in_low} right by amount, at most 4 bit positions per clock.
// Counts of 64 or more skip the iteration and produce the fill pattern
// directly; a count of zero finishes without shifting.
//
// Ports:
//   clock    single rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      srl_ll_seq_if.slave: start, in_high, in_low, amount, [arith],
//            res_high, res_low, busy, done
//
// Timing: with n = amount[5:0], done is high 1+ceil(n/4) edges after the
// accepting edge (counting that edge as the first); 1 edge for n==0 or
// amount>=64. The result stays on res_high/res_low until the next accepted
// start.
//
// Build option: SRL_LL_SEQ_ARITH_EN adds the arith input. When the latched
// arith is 1 the vacated bits are filled with bit 63 of the loaded operand;
// otherwise (and always in the default build) the fill is zero.
// ---------------------------------------------------------------------------
module srl_ll_seq (
    input  logic       clock,
    input  logic       reset_n,
    srl_ll_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } stateType;

    stateType    state;
    stateType    nextState;
    logic [63:0] dataReg;
    logic [63:0] dataNext;
    logic [6:0]  remReg;
    logic [6:0]  remNext;
    logic        fillReg;
    logic        fillNext;
    logic        loadFill;
    logic [2:0]  step;

    // Fill bit taken from the operand at the moment a start is accepted.
`ifdef SRL_LL_SEQ_ARITH_EN
    assign loadFill = bus.arith & bus.in_high[31];
`else
    assign loadFill = 1'b0;
`endif

    // Bits shifted this cycle: min(rem, 4).
    assign step = (remReg >= 7'd4) ? 3'd4 : remReg[2:0];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the data register is reset too because it drives the
    // result outputs directly and they must read zero out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            dataReg <= '0;
            remReg  <= '0;
            fillReg <= 1'b0;
        end else begin
            state   <= nextState;
            dataReg <= dataNext;
            remReg  <= remNext;
            fillReg <= fillNext;
        end
    end

    // NOTE: every variable written below gets a hold value first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        nextState = state;
        dataNext  = dataReg;
        remNext   = remReg;
        fillNext  = fillReg;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    fillNext = loadFill;
                    remNext  = {1'b0, bus.amount[5:0]};
                    if (bus.amount[31:6] != 26'd0) begin
                        // Everything shifts out: only fill remains.
                        dataNext  = {64{loadFill}};
                        nextState = DONE;
                    end else begin
                        dataNext  = {bus.in_high, bus.in_low};
                        nextState = (bus.amount[5:0] != 6'd0) ? SHIFT : DONE;
                    end
                end
            end

            SHIFT: begin
                case (step)
                    3'd1:    dataNext = {fillReg, dataReg[63:1]};
                    3'd2:    dataNext = {{2{fillReg}}, dataReg[63:2]};
                    3'd3:    dataNext = {{3{fillReg}}, dataReg[63:3]};
                    3'd4:    dataNext = {{4{fillReg}}, dataReg[63:4]};
                    default: dataNext = dataReg;
                endcase
                remNext = remReg - {4'd0, step};
                if (remReg == {4'd0, step}) begin
                    nextState = DONE;
                end
            end

            DONE: begin
                nextState = IDLE;
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign bus.res_high = dataReg[63:32];
    assign bus.res_low  = dataReg[31:0];
    assign bus.busy     = (state == SHIFT);
    assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_srl_ll_seq.sv
// ---------------------------------------------------------------------------
// tb_srl_ll_seq -- self-checking bench for srl_ll_seq.
//
// A transaction-level model predicts, from the shift rules alone, how many
// edges each accepted request takes and what 64-bit result it yields. One
// compare process checks busy, done and (outside busy) the result against
// that model on every falling edge. Directed sequences add hand-computed
// literal expectations. Define SRL_LL_SEQ_ARITH_EN to exercise the
// arithmetic variant.
// ---------------------------------------------------------------------------
module tb_srl_ll_seq;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    srl_ll_seq_if bus ();

    srl_ll_seq dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- model ----------------
    logic arithEff;
`ifdef SRL_LL_SEQ_ARITH_EN
    assign arithEff = bus.arith;
    localparam bit ARITH = 1'b1;
`else
    assign arithEff = 1'b0;
    localparam bit ARITH = 1'b0;
`endif

    function automatic int expEdges(input logic [31:0] amt);
        int n;
        n = int'(amt[5:0]);
        if (amt >= 32'd64 || n == 0) return 1;
        return 1 + (n + 3) / 4;
    endfunction

    function automatic logic [63:0] expResult(input logic [63:0] op, input logic [31:0] amt, input logic ar);
        logic [127:0] ext;
        logic         fill;
        fill = ar & op[63];
        if (amt >= 32'd64) return {64{fill}};
        ext = {{64{fill}}, op} >> amt[5:0];
        return ext[63:0];
    endfunction

    logic        modelActive;
    int          modelK;
    int          modelD;
    logic [63:0] modelRes;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            modelActive <= 1'b0;
            modelK      <= 0;
            modelD      <= 0;
            modelRes    <= '0;
        end else if (modelActive) begin
            modelK <= modelK + 1;
            if (modelK + 1 > modelD) modelActive <= 1'b0;
        end else if (bus.start) begin
            modelActive <= 1'b1;
            modelK      <= 1;
            modelD      <= expEdges(bus.amount);
            modelRes    <= expResult({bus.in_high, bus.in_low}, bus.amount, arithEff);
        end
    end

    always @(negedge clock) begin : compare
        logic expBusy;
        logic expDone;
        expBusy = modelActive && (modelK < modelD);
        expDone = modelActive && (modelK == modelD);
        check("busy", {63'd0, bus.busy}, {63'd0, expBusy});
        check("done", {63'd0, bus.done}, {63'd0, expDone});
        if (!expBusy) check("result", {bus.res_high, bus.res_low}, modelRes);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [63:0] op, input logic [31:0] amt, input logic ar);
        bus.in_high = op[63:32];
        bus.in_low  = op[31:0];
        bus.amount  = amt;
`ifdef SRL_LL_SEQ_ARITH_EN
        bus.arith   = ar;
`endif
        bus.start   = 1'b1;
    endtask

    // Starts from just before the accepting edge; returns at the falling edge
    // on which done is seen, with edges counted from the accepting edge.
    task automatic awaitDone(output int edges, output int busyCycles);
        edges = 0;
        busyCycles = 0;
        @(posedge clock);
        edges = 1;
        @(negedge clock);
        bus.start = 1'b0;
        if (bus.busy) busyCycles++;
        while (!bus.done && edges < 40) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (bus.busy) busyCycles++;
        end
        check("doneSeen", {63'd0, bus.done}, 64'd1);
    endtask

    task automatic runOp(input logic [63:0] op, input logic [31:0] amt, input logic ar,
                         output int edges, output int busyCycles);
        @(negedge clock);
        drive(op, amt, ar);
        awaitDone(edges, busyCycles);
    endtask

    function automatic logic [63:0] res();
        return {bus.res_high, bus.res_low};
    endfunction

    initial begin
        #200000;
        $display("FAIL globalTimeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequences ----------------
    initial begin
        int edges;
        int busyCycles;
        int donePulses;
        logic [63:0] resAtDone;

        bus.start   = 1'b0;
        bus.in_high = '0;
        bus.in_low  = '0;
        bus.amount  = '0;
`ifdef SRL_LL_SEQ_ARITH_EN
        bus.arith   = 1'b0;
`endif

        // Reset state.
        repeat (2) @(negedge clock);
        check("resetBusy", {63'd0, bus.busy}, 64'd0);
        check("resetDone", {63'd0, bus.done}, 64'd0);
        check("resetResult", res(), 64'd0);

        // Start already pending when reset releases: accepted on the first edge.
        drive(64'h8000_0000_0000_0000, 32'd1, 1'b0);
        #2 reset_n = 1'b1;
        awaitDone(edges, busyCycles);
        check("shift1Edges", edges, 2);
        check("shift1High", {32'd0, bus.res_high}, 64'h4000_0000);
        check("shift1Low", {32'd0, bus.res_low}, 64'd0);

        // 36-bit shift: 9 busy cycles, done at edge 10.
        runOp(64'h1234_5678_9ABC_DEF0, 32'd36, 1'b0, edges, busyCycles);
        check("shift36Edges", edges, 10);
        check("shift36Busy", busyCycles, 9);
        check("shift36High", {32'd0, bus.res_high}, 64'd0);
        check("shift36Low", {32'd0, bus.res_low}, 64'h0123_4567);

        // Zero count: done one edge after accept, operand unchanged.
        runOp(64'hDEAD_BEEF_CAFE_F00D, 32'd0, 1'b0, edges, busyCycles);
        check("shift0Edges", edges, 1);
        check("shift0Result", res(), 64'hDEAD_BEEF_CAFE_F00D);

        // Count of 64, logical then (optionally) arithmetic.
        runOp(64'hF000_0000_0000_0001, 32'h0000_0040, 1'b0, edges, busyCycles);
        check("shift64Edges", edges, 1);
        check("shift64Result", res(), 64'd0);
        runOp(64'hF000_0000_0000_0001, 32'h0000_0040, 1'b1, edges, busyCycles);
        check("shift64ArithEdges", edges, 1);
        check("shift64ArithResult", res(), ARITH ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);

        // Large count whose low bits are nonzero still short-circuits.
        runOp(64'h7FFF_FFFF_FFFF_FFFF, 32'h0001_0003, 1'b0, edges, busyCycles);
        check("shiftBigEdges", edges, 1);
        check("shiftBigResult", res(), 64'd0);

        // Partial final step (4 + 1).
        runOp(64'hFFFF_FFFF_FFFF_FFFF, 32'd5, 1'b0, edges, busyCycles);
        check("shift5Edges", edges, 3);
        check("shift5Result", res(), 64'h07FF_FFFF_FFFF_FFFF);

        // Exact multiple of 4.
        runOp(64'hA5A5_A5A5_A5A5_A5A5, 32'd4, 1'b0, edges, busyCycles);
        check("shift4Edges", edges, 2);
        check("shift4Result", res(), 64'h0A5A_5A5A_5A5A_5A5A);

        // Largest in-range count.
        runOp(64'h8000_0000_0000_0000, 32'd63, 1'b0, edges, busyCycles);
        check("shift63Edges", edges, 17);
        check("shift63Result", res(), 64'd1);

        // Arithmetic request on a negative operand.
        runOp(64'h8000_0000_0000_00FF, 32'd8, 1'b1, edges, busyCycles);
        check("shift8ArithEdges", edges, 3);
        check("shift8ArithResult", res(), ARITH ? 64'hFF80_0000_0000_0000 : 64'h0080_0000_0000_0000);

        // start pulsed during SHIFT and during DONE must be ignored.
        @(negedge clock);
        drive(64'h0123_4567_89AB_CDEF, 32'd12, 1'b0);
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        drive(64'h1111_2222_3333_4444, 32'd0, 1'b0);
        @(negedge clock);
        bus.start = 1'b0;
        donePulses = 0;
        resAtDone = '0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                donePulses++;
                resAtDone = res();
                drive(64'h5555_6666_7777_8888, 32'd0, 1'b0);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clock);
        end
        bus.start = 1'b0;
        check("ignoreDonePulses", donePulses, 1);
        check("ignoreResultAtDone", resAtDone, 64'h0000_1234_5678_9ABC);
        check("ignoreResultHeld", res(), 64'h0000_1234_5678_9ABC);

        // Reset during SHIFT: outputs clear at once, no done, restart works.
        @(negedge clock);
        drive(64'hFFFF_0000_FFFF_0000, 32'd20, 1'b0);
        repeat (3) @(posedge clock);
        bus.start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("abortBusy", {63'd0, bus.busy}, 64'd0);
        check("abortDone", {63'd0, bus.done}, 64'd0);
        check("abortResult", res(), 64'd0);
        donePulses = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.done) donePulses++;
        end
        check("abortNoDone", donePulses, 0);
        drive(64'hFFFF_0000_FFFF_0000, 32'd20, 1'b0);
        #2 reset_n = 1'b1;
        awaitDone(edges, busyCycles);
        check("restartEdges", edges, 6);
        check("restartBusy", busyCycles, 5);
        check("restartResult", res(), 64'h0000_0FFF_F000_0FFF);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/srl_ll_seq.md
SRL_LL_SEQ -- requirements
Module: srl_ll_seq

Interface
REQ-001 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-003 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a shift; sampled only in IDLE.
REQ-004 The block SHALL have ports in_high and in_low, input, 32 bits each, the upper and lower words of the 64-bit operand.
REQ-005 The block SHALL have port amount, input, 32 bits, an unsigned shift count.
REQ-006 The block SHALL have ports res_high and res_low, output, 32 bits each, the upper and lower words of the 64-bit result.
REQ-007 The block SHALL have port busy, output, 1 bit, high in SHIFT.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-009 The block SHALL have port arith, input, 1 bit, present only when SRL_LL_SEQ_ARITH_EN is defined.

Function
REQ-010 The block SHALL implement a 64-bit logical right shift of {in_high,in_low} by amount, computed iteratively.
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL load: data register <= {in_high,in_low}; remaining count rem (7 bits) <= amount[5:0].
REQ-013 From IDLE with start=1, the next state SHALL be SHIFT if amount[5:0]!=0 and amount[31:6]==0, else DONE.
REQ-014 If amount[31:6]!=0, the data register SHALL be loaded with zero (or sign-filled, see REQ-027) and the FSM SHALL go to DONE.
REQ-015 In each SHIFT cycle: step=min(rem,4); data >>= step with zero fill; rem -= step.
REQ-016 The FSM SHALL leave SHIFT for DONE on the edge where rem-step==0.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 done SHALL equal 1 only in DONE; busy SHALL equal 1 only in SHIFT.
REQ-019 Latency SHALL be: done is high in the cycle 1+ceil(n/4) edges after the start-sampling edge, where n=amount[5:0]; for n==0 or amount>=64, done is high 1 edge after.
REQ-020 res_high/res_low SHALL always reflect the data register, be valid in DONE and hold that value in IDLE until the next accepted start.
REQ-021 start SHALL be ignored in SHIFT and DONE (no queuing, no restart).
REQ-022 Inputs SHALL be sampled only on the accepting edge; later changes to the inputs do not affect the result.

Reset
REQ-023 While reset_n=0, the block SHALL be asynchronously forced to state=IDLE, data=0, rem=0, busy=0, done=0, res_high=0, res_low=0.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-025 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-026 SRL_LL_SEQ_ARITH_EN SHALL, when defined, add the arith port, latched with the operands on accept.
REQ-027 With SRL_LL_SEQ_ARITH_EN defined and latched arith=1, fill bits SHALL be copies of data bit 63 captured at load (arithmetic shift), and amount>=64 SHALL give all bits = bit 63.
REQ-028 Without SRL_LL_SEQ_ARITH_EN, the arith port SHALL be absent and the fill SHALL always be 0.

Verification
REQ-029 The bench SHALL check: in_high=32'h80000000, in_low=0, amount=1, start -> done at edge 2; res_high=32'h40000000, res_low=0.
REQ-030 The bench SHALL check: in_high=32'h12345678, in_low=32'h9ABCDEF0, amount=36 -> busy for 9 cycles, done at edge 10; res_high=0, res_low=32'h01234567.
REQ-031 The bench SHALL check: amount=0 with operand 64'hDEADBEEF_CAFEF00D -> done at edge 1; result equals the operand.
REQ-032 The bench SHALL check: amount=32'h00000040 (64) -> done at edge 1, result 0; with ARITH_EN, arith=1 and in_high[31]=1 -> result all ones.
REQ-033 The bench SHALL check: start pulsed again during SHIFT with new operands -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-034 The bench SHALL check: reset_n dropped during SHIFT at cycle 3 of amount=20 -> outputs 0 immediately, no done pulse; a new start after release completes normally.
